sysid_checker: RTL and testbench

- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its two readdata words.
- On request, reads word 0 (system ID) and word 1 (build timestamp), compares them against expected values, and retries a bounded number of times.
- Presents a latched pass/fail result plus the captured words to boot and sequencing logic, so firmware or hardware can refuse to run against a mismatched FPGA image.

---
 rtl/sysid_checker.sv | 197 +++++++++++++++++++
 tb/tb_sysid_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - Avalon-MM reader that verifies the system-ID and build timestamp words
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1457818839,
  parameter int          CHECK_TS     = 1,
  parameter int          READ_LATENCY = 0,
  parameter int          RETRY_LIMIT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WT_ID,
    RD_TS,
    WT_TS,
    CMP,
    DONE
  } state_t;

  // A zero-latency slave presents readdata in the accepting cycle, so the wait states are skipped.
  localparam bit         NO_WAIT    = (READ_LATENCY == 0);
  // Last value of the wait counter; the capture happens in that cycle.
  localparam logic [1:0] WAIT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [3:0] ATT_MAX    = 4'(RETRY_LIMIT);
  localparam bit         TS_CHECKED = (CHECK_TS != 0);

  state_t     state;
  state_t     state_n;
  logic [1:0] wait_cnt;

  logic start_chk;
  logic cap_id;
  logic cap_ts;
  logic cmp_en;
  logic retry;
  logic finish;
  logic id_diff;
  logic ts_diff;
  logic accepted;

  // Comparison of the words captured during the current attempt.
  assign id_diff  = (id_value != EXPECTED_ID);
  assign ts_diff  = TS_CHECKED && (ts_value != EXPECTED_TS);
  assign accepted = read && !waitrequest;

  // State register; reset abandons any read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counts cycles spent waiting for readdata after an accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= 2'd0;
    end else if (state == WT_ID || state == WT_TS) begin
      wait_cnt <= wait_cnt + 2'd1;
    end else begin
      wait_cnt <= 2'd0;
    end
  end

  // Next-state decode and bus strobes; address/read depend on state only so they stay stable across a stall.
  always_comb begin
    state_n   = state;
    address   = 1'b0;
    read      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    start_chk = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    cmp_en    = 1'b0;
    retry     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_chk = 1'b1;
          state_n   = RD_ID;
        end
      end
      RD_ID: begin
        read = 1'b1;
        if (accepted) begin
          if (NO_WAIT) begin
            cap_id  = 1'b1;
            state_n = RD_TS;
          end else begin
            state_n = WT_ID;
          end
        end
      end
      WT_ID: begin
        if (wait_cnt == WAIT_LAST) begin
          cap_id  = 1'b1;
          state_n = RD_TS;
        end
      end
      RD_TS: begin
        read    = 1'b1;
        address = 1'b1;
        if (accepted) begin
          if (NO_WAIT) begin
            cap_ts  = 1'b1;
            state_n = CMP;
          end else begin
            state_n = WT_TS;
          end
        end
      end
      WT_TS: begin
        if (wait_cnt == WAIT_LAST) begin
          cap_ts  = 1'b1;
          state_n = CMP;
        end
      end
      CMP: begin
        cmp_en = 1'b1;
        if ((id_diff || ts_diff) && (attempts < ATT_MAX)) begin
          retry   = 1'b1;
          state_n = RD_ID;
        end else begin
          finish  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          start_chk = 1'b1;
          state_n   = RD_ID;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Result and capture registers; results are cleared at the start of every check and held in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      attempts    <= 4'd0;
    end else begin
      if (start_chk) begin
        attempts    <= 4'd1;
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
      end
      if (cap_id) begin
        id_value <= readdata;
      end
      if (cap_ts) begin
        ts_value <= readdata;
      end
      if (cmp_en) begin
        id_mismatch <= id_diff;
        ts_mismatch <= ts_diff;
      end
      if (retry) begin
        attempts <= attempts + 4'd1;
      end
      if (finish) begin
        pass <= !(id_diff || ts_diff);
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - self-checking bench for sysid_checker
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457818839;
  localparam logic [31:0] BAD_TS = 32'd1457818838;
  localparam int          RETRY  = 3;
  localparam int          LAT_M  = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- main instance: default parameters ----------------
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        address_m, read_m, wait_m;
  logic [31:0] rdata_m;
  logic        busy_m, done_m, pass_m, idmm_m, tsmm_m;
  logic [31:0] idv_m, tsv_m;
  logic [3:0]  att_m;

  logic [31:0] cfg_id1 = EXP_ID;
  logic [31:0] cfg_id2 = EXP_ID;
  logic [31:0] cfg_ts  = EXP_TS;
  int          cfg_stall = 0;

  sysid_checker u_dut (
    .clock(clock), .reset(reset), .start(start),
    .address(address_m), .read(read_m), .waitrequest(wait_m), .readdata(rdata_m),
    .busy(busy_m), .done(done_m), .pass(pass_m),
    .id_mismatch(idmm_m), .ts_mismatch(tsmm_m),
    .id_value(idv_m), .ts_value(tsv_m), .attempts(att_m)
  );

  // Zero-latency slave: first ID read of a check returns cfg_id1, later ones cfg_id2;
  // the timestamp read is stalled for cfg_stall cycles once per check.
  int id_reads = 0;
  int stall_served = 0;
  assign wait_m  = read_m && address_m && (stall_served < cfg_stall);
  assign rdata_m = address_m ? cfg_ts : ((id_reads == 0) ? cfg_id1 : cfg_id2);
  always @(posedge clock) begin
    if (start && !busy_m) begin
      id_reads     <= 0;
      stall_served <= 0;
    end else begin
      if (read_m && !address_m && !wait_m) id_reads <= id_reads + 1;
      if (wait_m) stall_served <= stall_served + 1;
    end
  end

  // ---------------- behavioural model of the main instance ----------------
  bit          m_valid = 1'b0;
  int          m_phase = 0;     // 0 idle, 1 checking, 2 done
  int          m_done_at = 0;
  int          n_reads = 0;
  logic        m_pass = 1'b0, m_idmm = 1'b0, m_tsmm = 1'b0;
  logic [31:0] m_id = 32'd0, m_ts = 32'd0;
  int          m_att = 0;
  logic        p_pass, p_idmm, p_tsmm;
  logic [31:0] p_id;
  int          p_att;
  bit          prev_stall = 1'b0;
  logic        prev_addr = 1'b0;

  always @(negedge clock) begin
    if (m_phase == 1 && cyc == m_done_at) begin
      m_phase = 2;
      m_pass  = p_pass;
      m_idmm  = p_idmm;
      m_tsmm  = p_tsmm;
      m_id    = p_id;
      m_ts    = cfg_ts;
      m_att   = p_att;
    end
    if (m_valid) begin
      chk("m_busy", 32'(busy_m), 32'(m_phase == 1));
      chk("m_done", 32'(done_m), 32'(m_phase == 2));
      if (m_phase != 1) begin
        chk("m_read_quiet", 32'(read_m), 32'd0);
        chk("m_pass", 32'(pass_m), 32'(m_pass));
        chk("m_id_mm", 32'(idmm_m), 32'(m_idmm));
        chk("m_ts_mm", 32'(tsmm_m), 32'(m_tsmm));
        chk("m_id_value", idv_m, m_id);
        chk("m_ts_value", tsv_m, m_ts);
        chk("m_attempts", 32'(att_m), 32'(m_att));
        if (m_phase == 0) chk("m_addr_idle", 32'(address_m), 32'd0);
      end else begin
        chk("m_pass_busy", 32'(pass_m), 32'd0);
      end
      if (m_phase == 2 && cyc == m_done_at) chk("m_read_count", 32'(n_reads), 32'(2 * m_att));
      if (prev_stall) begin
        chk("m_stall_read", 32'(read_m), 32'd1);
        chk("m_stall_addr", 32'(address_m), 32'(prev_addr));
      end
    end
    prev_stall = read_m && wait_m;
    prev_addr  = address_m;
    if (read_m && !wait_m) n_reads++;
    if (reset) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_pass = 1'b0; m_idmm = 1'b0; m_tsmm = 1'b0;
      m_id = 32'd0; m_ts = 32'd0; m_att = 0;
      prev_stall = 1'b0;
    end else if (start && m_phase != 1) begin
      // Walk the attempts the slave program will produce until one matches or the limit is hit.
      for (int n = 1; n <= RETRY; n++) begin
        p_att  = n;
        p_id   = (n == 1) ? cfg_id1 : cfg_id2;
        p_idmm = (p_id != EXP_ID);
        p_tsmm = (cfg_ts != EXP_TS);
        if (!(p_idmm || p_tsmm)) break;
      end
      p_pass    = !(p_idmm || p_tsmm);
      m_done_at = cyc + 4 + 2 * LAT_M + (p_att - 1) * (3 + 2 * LAT_M) + cfg_stall;
      m_phase   = 1;
      m_pass = 1'b0; m_idmm = 1'b0; m_tsmm = 1'b0;
      n_reads   = 0;
    end
  end

  // ---------------- CHECK_TS=0 instance ----------------
  logic        start_n = 1'b0;
  logic        address_n, read_n;
  logic [31:0] rdata_n;
  logic        busy_n, done_n, pass_n, idmm_n, tsmm_n;
  logic [31:0] idv_n, tsv_n;
  logic [3:0]  att_n;
  assign rdata_n = address_n ? BAD_TS : EXP_ID;

  sysid_checker #(.CHECK_TS(0)) u_nots (
    .clock(clock), .reset(reset), .start(start_n),
    .address(address_n), .read(read_n), .waitrequest(1'b0), .readdata(rdata_n),
    .busy(busy_n), .done(done_n), .pass(pass_n),
    .id_mismatch(idmm_n), .ts_mismatch(tsmm_n),
    .id_value(idv_n), .ts_value(tsv_n), .attempts(att_n)
  );

  // ---------------- READ_LATENCY=2 instance ----------------
  logic        rst_l = 1'b1;
  logic        start_l = 1'b0;
  logic        address_l, read_l;
  logic [31:0] rdata_l;
  logic        busy_l, done_l, pass_l, idmm_l, tsmm_l;
  logic [31:0] idv_l, tsv_l;
  logic [3:0]  att_l;
  logic [31:0] pipe0 = 32'hdeadbeef, pipe1 = 32'hdeadbeef;
  // Data is valid exactly two cycles after an accepted read; garbage otherwise.
  always @(posedge clock) begin
    pipe0 <= read_l ? (address_l ? EXP_TS : EXP_ID) : 32'hdeadbeef;
    pipe1 <= pipe0;
  end
  assign rdata_l = pipe1;

  sysid_checker #(.READ_LATENCY(2)) u_lat2 (
    .clock(clock), .reset(rst_l), .start(start_l),
    .address(address_l), .read(read_l), .waitrequest(1'b0), .readdata(rdata_l),
    .busy(busy_l), .done(done_l), .pass(pass_l),
    .id_mismatch(idmm_l), .ts_mismatch(tsmm_l),
    .id_value(idv_l), .ts_value(tsv_l), .attempts(att_l)
  );

  task automatic go_main(input logic [31:0] id1, input logic [31:0] id2, input logic [31:0] ts,
                         input int stall, input int exp_dur, input logic exp_pass, input logic [3:0] exp_att);
    int s;
    int n;
    cfg_id1 = id1; cfg_id2 = id2; cfg_ts = ts; cfg_stall = stall;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    @(negedge clock);
    chk("start_busy", 32'(busy_m), 32'd1);
    chk("start_pass_clr", 32'(pass_m), 32'd0);
    chk("start_id_mm_clr", 32'(idmm_m), 32'd0);
    chk("start_ts_mm_clr", 32'(tsmm_m), 32'd0);
    n = 0;
    while (!done_m && n < 200) begin @(negedge clock); n++; end
    chk("done_cycle", 32'(cyc - s), 32'(exp_dur));
    chk("pass", 32'(pass_m), 32'(exp_pass));
    chk("attempts", 32'(att_m), 32'(exp_att));
    tick();
  endtask

  task automatic wait_done_l(input int s, input int exp_dur);
    int n;
    n = 0;
    while (!done_l && n < 200) begin @(negedge clock); n++; end
    chk("lat2_done_cycle", 32'(cyc - s), 32'(exp_dur));
    chk("lat2_pass", 32'(pass_l), 32'd1);
    chk("lat2_attempts", 32'(att_l), 32'd1);
    chk("lat2_ts_value", tsv_l, EXP_TS);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    repeat (3) tick();
    reset = 1'b0;
    rst_l = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_done", 32'(done_m), 32'd0);
    chk("rst_read", 32'(read_m), 32'd0);
    chk("rst_attempts", 32'(att_m), 32'd0);
    tick();

    // Good image, no stall.
    go_main(EXP_ID, EXP_ID, EXP_TS, 0, 4, 1'b1, 4'd1);
    chk("t1_id_value", idv_m, 32'd0);
    chk("t1_ts_value", tsv_m, 32'd1457818839);

    // Persistent timestamp mismatch: three attempts, fail.
    go_main(EXP_ID, EXP_ID, BAD_TS, 0, 10, 1'b0, 4'd3);
    chk("t2_ts_mm", 32'(tsmm_m), 32'd1);
    chk("t2_id_mm", 32'(idmm_m), 32'd0);
    chk("t2_ts_value", tsv_m, 32'd1457818838);

    // ID wrong on first attempt only.
    go_main(32'd5, EXP_ID, EXP_TS, 0, 7, 1'b1, 4'd2);
    chk("t3_id_mm", 32'(idmm_m), 32'd0);

    // Five-cycle stall on the timestamp read.
    go_main(EXP_ID, EXP_ID, EXP_TS, 5, 9, 1'b1, 4'd1);

    // start pulsed while busy is ignored.
    cfg_stall = 0;
    start = 1'b1; s = cyc; tick(); start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done_m && n < 200) begin @(negedge clock); n++; end
    chk("t5_done_cycle", 32'(cyc - s), 32'd4);
    repeat (6) tick();
    @(negedge clock);
    chk("t5_done_held", 32'(done_m), 32'd1);
    chk("t5_attempts", 32'(att_m), 32'd1);
    tick();

    // CHECK_TS=0: bad timestamp captured but not judged.
    start_n = 1'b1; s = cyc; tick(); start_n = 1'b0;
    n = 0;
    while (!done_n && n < 200) begin @(negedge clock); n++; end
    chk("nots_done_cycle", 32'(cyc - s), 32'd4);
    chk("nots_pass", 32'(pass_n), 32'd1);
    chk("nots_attempts", 32'(att_n), 32'd1);
    chk("nots_ts_mm", 32'(tsmm_n), 32'd0);
    chk("nots_ts_value", tsv_n, BAD_TS);
    tick();

    // READ_LATENCY=2, then reset in WT_TS, then a clean re-run.
    start_l = 1'b1; s = cyc; tick(); start_l = 1'b0;
    wait_done_l(s, 8);
    tick();
    start_l = 1'b1; tick(); start_l = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    chk("lat2_in_wait_busy", 32'(busy_l), 32'd1);
    chk("lat2_in_wait_read", 32'(read_l), 32'd0);
    rst_l = 1'b1;
    tick();
    rst_l = 1'b0;
    @(negedge clock);
    chk("lat2_rst_busy", 32'(busy_l), 32'd0);
    chk("lat2_rst_done", 32'(done_l), 32'd0);
    chk("lat2_rst_read", 32'(read_l), 32'd0);
    chk("lat2_rst_addr", 32'(address_l), 32'd0);
    chk("lat2_rst_pass", 32'(pass_l), 32'd0);
    chk("lat2_rst_mm", 32'({idmm_l, tsmm_l}), 32'd0);
    chk("lat2_rst_attempts", 32'(att_l), 32'd0);
    chk("lat2_rst_id", idv_l, 32'd0);
    chk("lat2_rst_ts", tsv_l, 32'd0);
    repeat (3) tick();
    @(negedge clock);
    chk("lat2_late_busy", 32'(busy_l), 32'd0);
    chk("lat2_late_ts", tsv_l, 32'd0);
    tick();
    start_l = 1'b1; s = cyc; tick(); start_l = 1'b0;
    wait_done_l(s, 8);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
